// File: rtl/adc_input_spi_reader.sv
// Serial ADC frame reader: CS/SCLK sequencing, lead-bit check and 16-bit capture.
// Optional threshold comparator on the captured sample: `define ADC_INPUT_THRSH_EN.
module adc_input_spi_reader #(
   parameter int SCLK_DIV   = 2,
   parameter int CS_SETUP   = 2,
   parameter int LEAD_BITS  = 4,
   parameter int DATA_BITS  = 16,
   parameter int TRAIL_BITS = 4,
   parameter int QUIET      = 4
) (
   input  logic        dataclk,
   input  logic        reset_n,
   input  logic        start,
   output logic        ADC_CS,
   output logic        ADC_SCLK,
   input  logic        ADC_DOUT,
   output logic [15:0] ADC_data,
   output logic        ADC_valid,
   output logic        ADC_frame_err,
   output logic        busy,
   input  logic [15:0] ADC_thrsh,
   input  logic        ADC_thrsh_pol,
   input  logic [7:0]  ADC_hyst,
   output logic        ADC_thrsh_out
);

   localparam int N = LEAD_BITS + DATA_BITS + TRAIL_BITS;
   localparam logic [15:0] DIV_LAST   = 16'(SCLK_DIV - 1);
   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] QUIET_LAST = 16'(QUIET - 1);
   localparam logic [7:0]  BIT_LAST   = 8'(N - 1);
   localparam logic [7:0]  LEAD_END   = 8'(LEAD_BITS);
   localparam logic [7:0]  DATA_END   = 8'(LEAD_BITS + DATA_BITS);

   typedef enum logic [1:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_QUIET
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  bit_q, bit_d;
   logic        phase_q, phase_d;
   logic        sample, done;
   logic        cs_d, sclk_d;
   logic        cs_q, sclk_q;
   logic [15:0] shreg_q;
   logic        err_q;
   logic [15:0] data_q;
   logic        ferr_q;
   logic        valid_q;

   // CS/SCLK are registered from next-state decode so the pins never glitch
   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      sample  = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETUP;
               cnt_d   = '0;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               bit_d   = '0;
               phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
               if (!phase_q) begin
                  sample = 1'b1;
               end else if (bit_q == BIT_LAST) begin
                  done    = 1'b1;
                  state_d = S_QUIET;
               end else begin
                  bit_d = bit_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_QUIET: begin
            if (cnt_q == QUIET_LAST)
               state_d = S_IDLE;
            else
               cnt_d = cnt_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cs_d   = (state_d == S_IDLE) || (state_d == S_QUIET);
      sclk_d = !((state_d == S_SHIFT) && !phase_d);
      busy   = (state_q != S_IDLE);
   end

   // sample coincides with the edge that raises SCLK
   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         ferr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= done;
         if ((state_q == S_IDLE) && start)
            err_q <= 1'b0;
         if (sample) begin
            if (bit_q < LEAD_END)
               err_q <= err_q | ADC_DOUT;
            else if (bit_q < DATA_END)
               shreg_q <= {shreg_q[14:0], ADC_DOUT};
         end
         if (done) begin
            data_q <= shreg_q;
            ferr_q <= err_q;
         end
      end
   end

   assign ADC_CS        = cs_q;
   assign ADC_SCLK      = sclk_q;
   assign ADC_data      = data_q;
   assign ADC_valid     = valid_q;
   assign ADC_frame_err = ferr_q;

`ifdef ADC_INPUT_THRSH_EN
   logic [16:0] lo;
   logic [16:0] hi;
   logic        thr_q;

   // bit 16 flags underflow/overflow, i.e. the clear bound is clamped away
   always_comb begin
      lo = {1'b0, ADC_thrsh} - {9'd0, ADC_hyst};
      hi = {1'b0, ADC_thrsh} + {9'd0, ADC_hyst};
   end

   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         thr_q <= 1'b0;
      end else if (valid_q) begin
         if (ADC_thrsh_pol) begin
            if (data_q >= ADC_thrsh)
               thr_q <= 1'b1;
            else if (!lo[16] && ({1'b0, data_q} < lo))
               thr_q <= 1'b0;
         end else begin
            if (data_q <= ADC_thrsh)
               thr_q <= 1'b1;
            else if (!hi[16] && ({1'b0, data_q} > hi))
               thr_q <= 1'b0;
         end
      end
   end

   assign ADC_thrsh_out = thr_q;
`else
   logic unused_thr;
   assign unused_thr    = ^{ADC_thrsh, ADC_thrsh_pol, ADC_hyst};
   assign ADC_thrsh_out = 1'b0;
`endif

endmodule

// File: tb/tb_adc_input_spi_reader.sv
// Bench for adc_input_spi_reader: two instances (default and fast SCLK),
// behavioural ADC serialiser and threshold reference model.
module tb_adc_input_spi_reader;

`ifdef ADC_INPUT_THRSH_EN
   localparam bit THR_EN = 1'b1;
`else
   localparam bit THR_EN = 1'b0;
`endif

   logic        dataclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic        dout0 = 1'b0, dout1 = 1'b0;
   logic        cs0, sclk0, valid0, ferr0, busy0, thr0;
   logic        cs1, sclk1, valid1, ferr1, busy1, thr1;
   logic [15:0] data0, data1;
   logic [15:0] thrsh = 16'h0;
   logic        pol = 1'b1;
   logic [7:0]  hyst = 8'h0;
   logic [23:0] frm0 = '0, frm1 = '0;
   int          idx0 = 0, idx1 = 0, rises0 = 0, rises1 = 0;
   int          n_tests = 0, n_fail = 0;
   logic        exp_thr0 = 1'b0, exp_thr1 = 1'b0;
   logic        last_busy_pre = 1'b0;

   always #5 dataclk = ~dataclk;

   adc_input_spi_reader u0 (
      .dataclk(dataclk), .reset_n(reset_n), .start(start0),
      .ADC_CS(cs0), .ADC_SCLK(sclk0), .ADC_DOUT(dout0),
      .ADC_data(data0), .ADC_valid(valid0), .ADC_frame_err(ferr0),
      .busy(busy0), .ADC_thrsh(thrsh), .ADC_thrsh_pol(pol),
      .ADC_hyst(hyst), .ADC_thrsh_out(thr0)
   );

   adc_input_spi_reader #(.SCLK_DIV(1), .CS_SETUP(1)) u1 (
      .dataclk(dataclk), .reset_n(reset_n), .start(start1),
      .ADC_CS(cs1), .ADC_SCLK(sclk1), .ADC_DOUT(dout1),
      .ADC_data(data1), .ADC_valid(valid1), .ADC_frame_err(ferr1),
      .busy(busy1), .ADC_thrsh(thrsh), .ADC_thrsh_pol(pol),
      .ADC_hyst(hyst), .ADC_thrsh_out(thr1)
   );

   // ADC model: shifts the next frame bit out on each SCLK fall
   always @(negedge cs0) begin idx0 = 0; rises0 = 0; end
   always @(negedge sclk0) if (!cs0) begin
      dout0 = (idx0 < 24) ? frm0[23-idx0] : 1'b0;
      idx0++;
   end
   always @(posedge sclk0) if (!cs0) rises0++;

   always @(negedge cs1) begin idx1 = 0; rises1 = 0; end
   always @(negedge sclk1) if (!cs1) begin
      dout1 = (idx1 < 24) ? frm1[23-idx1] : 1'b0;
      idx1++;
   end
   always @(posedge sclk1) if (!cs1) rises1++;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic thr_model(input logic cur, input int d);
      int t, h, lo, hi;
      t  = int'(thrsh);
      h  = int'(hyst);
      lo = t - h;
      if (lo < 0) lo = 0;
      hi = t + h;
      if (hi > 65535) hi = 65535;
      if (pol) begin
         if (d >= t) return 1'b1;
         if (d < lo) return 1'b0;
      end else begin
         if (d <= t) return 1'b1;
         if (d > hi) return 1'b0;
      end
      return cur;
   endfunction

   // Called at a negedge; start is high for that cycle. k counts cycles after it.
   task automatic run_frame(input bit sel, input logic [23:0] f,
                            input int stray, input int len,
                            output int lat, output int np,
                            output logic [15:0] d, output logic e,
                            output logic th, output logic bp);
      if (sel) frm1 = f; else frm0 = f;
      lat = -1; np = 0; d = '0; e = 1'b0; th = 1'b0; bp = 1'b0;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge dataclk);
      for (int k = 1; k < len; k++) begin
         if (sel) start1 = (k == stray); else start0 = (k == stray);
         if (sel ? valid1 : valid0) begin
            np++;
            if (lat < 0) begin
               lat = k;
               d = sel ? data1 : data0;
               e = sel ? ferr1 : ferr0;
            end
         end
         if (lat > 0 && k == lat + 1) th = sel ? thr1 : thr0;
         if (k == len - 1) bp = sel ? busy1 : busy0;
         @(negedge dataclk);
      end
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic frame(input bit sel, input logic [3:0] lead,
                        input logic [15:0] dat, input int stray,
                        input int len);
      int lat, np;
      logic [15:0] d;
      logic e, th, bp, exp_th;
      logic [3:0] tr;
      tr = 4'($urandom);
      run_frame(sel, {lead, dat, tr}, stray, len, lat, np, d, e, th, bp);
      check("latency", lat, sel ? 50 : 99);
      check("valid_pulses", np, 1);
      check("data", d, dat);
      check("frame_err", e, lead != 4'h0);
      check("sclk_rises", sel ? rises1 : rises0, 24);
      check("cs_after", sel ? cs1 : cs0, 1);
      check("sclk_after", sel ? sclk1 : sclk0, 1);
      if (sel) begin
         exp_thr1 = thr_model(exp_thr1, int'(dat));
         exp_th = exp_thr1;
      end else begin
         exp_thr0 = thr_model(exp_thr0, int'(dat));
         exp_th = exp_thr0;
      end
      check("thrsh_out", th, THR_EN ? exp_th : 1'b0);
      last_busy_pre = bp;
   endtask

   initial begin
      int np;
      logic [3:0] ld;
      logic [15:0] dv;

      repeat (3) @(negedge dataclk);
      check("rst_cs", cs0, 1);
      check("rst_sclk", sclk0, 1);
      check("rst_data", data0, 0);
      check("rst_valid", valid0, 0);
      check("rst_ferr", ferr0, 0);
      check("rst_busy", busy0, 0);
      check("rst_thr", thr0, 0);
      reset_n = 1'b1;
      @(negedge dataclk);

      frame(0, 4'h0, 16'hA5C3, 0, 110);
      frame(0, 4'b0010, 16'h1234, 0, 110);

      // stray start mid-frame, then restart in the first IDLE cycle
      frame(0, 4'h0, 16'h5A5A, 40, 103);
      check("busy_last_quiet", last_busy_pre, 1);
      check("idle_at_103", busy0, 0);
      frame(0, 4'h0, 16'h0F0F, 0, 110);

      // asynchronous reset mid-frame
      frm0 = {4'h0, 16'hFFFF, 4'h0};
      start0 = 1'b1;
      @(negedge dataclk);
      start0 = 1'b0;
      repeat (49) @(negedge dataclk);
      check("midframe_busy", busy0, 1);
      check("midframe_cs", cs0, 0);
      #2 reset_n = 1'b0;
      #1;
      check("abort_cs", cs0, 1);
      check("abort_sclk", sclk0, 1);
      check("abort_busy", busy0, 0);
      check("abort_data", data0, 0);
      check("abort_valid", valid0, 0);
      check("abort_thr", thr0, 0);
      exp_thr0 = 1'b0;
      exp_thr1 = 1'b0;
      @(negedge dataclk);
      reset_n = 1'b1;
      np = 0;
      repeat (120) begin
         @(negedge dataclk);
         if (valid0) np++;
      end
      check("abort_no_valid", np, 0);
      check("abort_data_hold", data0, 0);

      frame(1, 4'h0, 16'hC0DE, 0, 60);
      frame(1, 4'b1000, 16'h8001, 0, 60);

      thrsh = 16'h8000;
      pol   = 1'b1;
      hyst  = 8'h10;
      frame(0, 4'h0, 16'h8000, 0, 110);
      frame(0, 4'h0, 16'h7FF5, 0, 110);
      frame(0, 4'h0, 16'h7FEF, 0, 110);

      for (int i = 0; i < 12; i++) begin
         thrsh = 16'($urandom);
         pol   = 1'($urandom);
         hyst  = 8'($urandom);
         ld    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 1) == 1)
            dv = thrsh + 16'($urandom_range(0, 600)) - 16'd300;
         else
            dv = 16'($urandom);
         frame((i % 3) == 2, ld, dv, 0, ((i % 3) == 2) ? 60 : 110);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
